// File: rtl/cfg_link_pkg.sv
// Shared types for the serial configuration link readback checker.
package cfg_link_pkg;

    localparam int FRAME_LEN_DEFAULT = 104;
    localparam int DYN_LEN           = 16;
    localparam int STAT_LEN          = 88;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        END,
        CHECK,
        REPORT
    } state_t;

    typedef struct packed {
        logic sel;
        logic mosi;
        logic sdo;
        logic rise;
    } samp_t;

endpackage

// File: rtl/ser_edge_sampler.sv
// Registers the serial link pins into the CLK domain and flags ser_clk rises.
module ser_edge_sampler
    import cfg_link_pkg::*;
#(
    parameter logic SEL_IDLE = 1'b1
) (
    input  logic  CLK,
    input  logic  RST_N,
    input  logic  ser_clk_in,
    input  logic  sel_in,
    input  logic  mosi_in,
    input  logic  sdo_in,
    output samp_t samp
);

    logic ser_q;
    logic ser_d;
    logic sel_q;
    logic mosi_q;
    logic sdo_q;

    // sel resets to its idle level so leaving reset never looks like a frame
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ser_q  <= 1'b0;
            ser_d  <= 1'b0;
            sel_q  <= SEL_IDLE;
            mosi_q <= 1'b0;
            sdo_q  <= 1'b0;
        end else begin
            ser_q  <= ser_clk_in;
            ser_d  <= ser_q;
            sel_q  <= sel_in;
            mosi_q <= mosi_in;
            sdo_q  <= sdo_in;
        end
    end

    always_comb begin
        samp      = '0;
        samp.sel  = sel_q;
        samp.mosi = mosi_q;
        samp.sdo  = sdo_q;
        samp.rise = ser_q & ~ser_d;
    end

endmodule

// File: rtl/cfg_readback_checker.sv
// Captures each config frame and checks the next frame's SDO return
// against it, since the shift chain echoes its previous contents.
module cfg_readback_checker
    import cfg_link_pkg::*;
#(
    parameter int   FRAME_LEN  = FRAME_LEN_DEFAULT,
    parameter logic SEL_ACTIVE = 1'b0,
    parameter int   CNTW       = 8,
    parameter int   IDXW       = 7
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            ser_clk_in,
    input  logic            sel_in,
    input  logic            mosi_in,
    input  logic            sdo_in,
    input  logic            clear,
    output logic            result_valid,
    output logic            pass,
    output logic [CNTW-1:0] err_count,
    output logic [IDXW-1:0] first_err_idx,
    output logic [CNTW-1:0] bit_count,
    output logic            len_err,
    output logic            overrun
);

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] LEN_C   = CNTW'(FRAME_LEN);
    localparam logic [IDXW-1:0] LAST_C  = IDXW'(FRAME_LEN - 1);

    samp_t s;

    state_t state;
    state_t state_nxt;

    logic [CNTW-1:0]      bit_cnt;
    logic [CNTW-1:0]      acc;
    logic [CNTW-1:0]      acc_nxt;
    logic [IDXW-1:0]      chk_idx;
    logic [IDXW-1:0]      first_idx;
    logic [IDXW-1:0]      first_nxt;
    logic [IDXW-1:0]      wr_idx;
    logic                 first_seen;
    logic                 ref_valid;
    logic [FRAME_LEN-1:0] cap_mosi;
    logic [FRAME_LEN-1:0] cap_sdo;
    logic [FRAME_LEN-1:0] ref_bits;

    logic sel_act;
    logic len_ok;
    logic chk_last;
    logic mism;
    logic do_start;
    logic do_store;
    logic do_count;
    logic do_end;
    logic do_abort;
    logic do_cmp;
    logic do_load;

    ser_edge_sampler #(
        .SEL_IDLE (~SEL_ACTIVE)
    ) u_sampler (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .ser_clk_in (ser_clk_in),
        .sel_in     (sel_in),
        .mosi_in    (mosi_in),
        .sdo_in     (sdo_in),
        .samp       (s)
    );

    assign sel_act  = (s.sel == SEL_ACTIVE);
    assign len_ok   = (bit_cnt == LEN_C);
    assign chk_last = (chk_idx == LAST_C);
    assign wr_idx   = bit_cnt[IDXW-1:0];
    assign mism     = cap_sdo[chk_idx] ^ ref_bits[chk_idx];

    assign acc_nxt   = (mism && acc != CNT_MAX) ? acc + CNTW'(1) : acc;
    assign first_nxt = (mism && !first_seen) ? chk_idx : first_idx;

    always_ff @(posedge CLK) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (sel_act) state_nxt = SHIFT;
                SHIFT:   if (!sel_act) state_nxt = END;
                END:     state_nxt = (len_ok && ref_valid) ? CHECK : IDLE;
                CHECK: begin
                    if (sel_act)       state_nxt = SHIFT;
                    else if (chk_last) state_nxt = REPORT;
                end
                REPORT:  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        do_start     = 1'b0;
        do_store     = 1'b0;
        do_count     = 1'b0;
        do_end       = 1'b0;
        do_abort     = 1'b0;
        do_cmp       = 1'b0;
        do_load      = 1'b0;
        result_valid = 1'b0;
        unique case (state)
            IDLE:  do_start = sel_act;
            SHIFT: begin
                do_store = sel_act && s.rise && bit_cnt < LEN_C;
                do_count = sel_act && s.rise && bit_cnt != CNT_MAX;
            end
            END:   do_end = 1'b1;
            CHECK: begin
                do_start = sel_act;
                do_abort = sel_act;
                do_cmp   = !sel_act;
                do_load  = !sel_act && chk_last;
            end
            REPORT:  result_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            bit_cnt       <= '0;
            acc           <= '0;
            chk_idx       <= '0;
            first_idx     <= '0;
            first_seen    <= 1'b0;
            ref_valid     <= 1'b0;
            cap_mosi      <= '0;
            cap_sdo       <= '0;
            ref_bits      <= '0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
            bit_count     <= '0;
            len_err       <= 1'b0;
            overrun       <= 1'b0;
        end else if (clear) begin
            ref_valid <= 1'b0;
            len_err   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (do_start) bit_cnt <= '0;
            if (do_store) begin
                cap_mosi[wr_idx] <= s.mosi;
                cap_sdo[wr_idx]  <= s.sdo;
            end
            if (do_count) bit_cnt <= bit_cnt + CNTW'(1);
            if (do_abort) begin
                overrun   <= 1'b1;
                ref_valid <= 1'b0;
            end
            if (do_end) begin
                bit_count  <= bit_cnt;
                chk_idx    <= '0;
                acc        <= '0;
                first_idx  <= '0;
                first_seen <= 1'b0;
                if (!len_ok) begin
                    len_err   <= 1'b1;
                    ref_valid <= 1'b0;
                end else if (!ref_valid) begin
                    ref_bits  <= cap_mosi;
                    ref_valid <= 1'b1;
                end
            end
            if (do_cmp) begin
                chk_idx    <= chk_idx + IDXW'(1);
                acc        <= acc_nxt;
                first_idx  <= first_nxt;
                first_seen <= first_seen | mism;
            end
            // results land with the last compare so they are valid in REPORT
            if (do_load) begin
                err_count     <= acc_nxt;
                first_err_idx <= first_nxt;
                pass          <= (acc_nxt == '0);
                ref_bits      <= cap_mosi;
            end
        end
    end

endmodule
